// File: rtl/reg_snapshot_reader_pkg.sv
// Shared types and constants for the x/y snapshot readback path.
package reg_snapshot_reader_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Register block widths; the readback frame must track these.
  localparam int DEF_XW = 3;
  localparam int DEF_YW = 8;

  function automatic int frame_len(input int xw, input int yw);
    return xw + yw;
  endfunction

endpackage

// File: rtl/reg_snapshot_reader_if.sv
// Bit-serial readout channel. Valid/ready: a bit transfers on a rising edge where
// sout_valid and sout_ready are both high; once valid rises, data/last hold until that transfer.
interface reg_snapshot_reader_if;
  logic sout_valid;
  logic sout_data;
  logic sout_last;
  logic sout_ready;

  modport master (output sout_valid, output sout_data, output sout_last, input sout_ready);
  modport slave  (input sout_valid, input sout_data, input sout_last, output sout_ready);
endinterface

// File: rtl/reg_snapshot_reader_piso_shifter.sv
// Parallel-load, LSB-first shift register with a bit counter and last-bit flag.
module piso_shifter #(
  parameter int W  = 11,
  parameter int CW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         shift_i,
  output logic         bit_o,
  output logic         last_o
);

  logic [W-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shreg_d = load_data_i;
      cnt_d   = '0;
    end else if (shift_i) begin
      shreg_d = {1'b0, shreg_q[W-1:1]};
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bit_o  = shreg_q[0];
  assign last_o = (cnt_q == CW'(W - 1));

endmodule

// File: rtl/reg_snapshot_reader.sv
// Captures live x/y register values on request and streams {y, x} LSB first.
module reg_snapshot_reader
  import reg_snapshot_reader_pkg::*;
#(
  parameter int XW = DEF_XW,
  parameter int YW = DEF_YW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [XW-1:0]          x_val,
  input  logic [YW-1:0]          y_val,
  input  logic                   snap_req,
  input  logic                   clr_drop,
  output logic                   busy,
  output logic                   snap_done,
  output logic                   snap_drop,
  reg_snapshot_reader_if.master  sout,
  output state_e                 dbg_state_o
);

  localparam int FW = frame_len(XW, YW);
  localparam int CW = (FW > 1) ? $clog2(FW) : 1;

  state_e state_q, state_d;
  logic   done_q, done_d;
  logic   drop_q, drop_d;
  logic   load, shift, sh_bit, sh_last;

  piso_shifter #(.W(FW), .CW(CW)) u_piso (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .load_data_i ({y_val, x_val}),
    .shift_i     (shift),
    .bit_o       (sh_bit),
    .last_o      (sh_last)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (snap_req) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift = sout.sout_ready;
        if (sout.sout_ready && sh_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  // A request that finds the shifter busy only leaves a sticky mark; set beats clear.
  always_comb begin
    drop_d = drop_q;
    if (state_q == SHIFT && snap_req) drop_d = 1'b1;
    else if (clr_drop)                drop_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign busy            = (state_q == SHIFT);
  assign sout.sout_valid = busy;
  assign sout.sout_data  = busy & sh_bit;
  assign sout.sout_last  = busy & sh_last;
  assign snap_done       = done_q;
  assign snap_drop       = drop_q;
  assign dbg_state_o     = state_q;

endmodule

// File: doc/reg_snapshot_reader.md
Name: reg_snapshot_reader

Overview:
- Readback counterpart to the init-loaded register pair. Where the register block loads x/y state from parallel init inputs at reset, this block captures the live x/y register values on request and shifts them out serially.
- Output is a bit-serial stream with a valid/ready handshake, consumed by the debug/scan readout path.
- Sits beside the register block, taps its x/y outputs, and drives the readout channel.

Parameters:
- XW, 3, width of x register value.
- YW, 8, width of y register value.
- FW, XW+YW (derived, not overridable), frame length in bits.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- x_val  input  XW  live x register value.
- y_val  input  YW  live y register value.
- snap_req  input  1  single-cycle request to capture and stream a snapshot.
- clr_drop  input  1  clears the sticky drop flag.
- busy  output  1  high while a frame is captured or streaming.
- sout_valid  output  1  serial bit valid.
- sout_data  output  1  serial bit.
- sout_last  output  1  marks the final bit of the frame; valid only with sout_valid.
- sout_ready  input  1  downstream accepts the bit.
- snap_done  output  1  one-cycle pulse after the last bit's handshake.
- snap_drop  output  1  sticky: a request arrived while busy.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, shift register=0, bit counter=0.
  - busy, sout_valid, sout_data, sout_last, snap_done and snap_drop all 0.
- Frame format: {y_val, x_val}, sent LSB first. Bit 0 is x_val[0], bit XW is y_val[0], and the last bit is y_val[YW-1].
- State IDLE:
  - On snap_req=1, latch {y_val, x_val} into the FW-bit shift register, set count=0, go to SHIFT.
  - Latency: a request in cycle N gives sout_valid=1 in cycle N+1, with data sampled at edge N.
- State SHIFT:
  - sout_valid=1, sout_data=shreg[0], sout_last=(count==FW-1).
  - On sout_valid & sout_ready: shift right by 1 and increment count.
  - If the handshake is on the last bit: go to IDLE and pulse snap_done=1 in the next cycle.
  - When sout_ready=0: data, last and count hold stable and valid stays high. The stream must not retract.
- busy = (state==SHIFT). It drops in the same cycle snap_done pulses.
- Request while busy:
  - The request is ignored; the frame in flight is unaffected.
  - snap_drop is set to 1 and held until clr_drop.
- snap_req and clr_drop in the same cycle while busy: the set wins, so snap_drop stays 1.
- Back-to-back: snap_req in the snap_done cycle is accepted, since the state is already IDLE. The next frame starts valid one cycle later.
- x_val/y_val changing during SHIFT has no effect on the frame in flight.
- Reset mid-frame: the frame is abandoned immediately and sout_valid drops asynchronously. No snap_done is issued.
- Counter width: clog2(FW). No wrap can occur, because the count resets on every capture.

Decomposition:
- Shared package holds:
  - state enum {IDLE, SHIFT};
  - default XW/YW constants shared with the register block;
  - a frame-length function.
- One natural sub-module, piso_shifter: a parallel-load, shift-on-enable, LSB-first shift register with count and last.
- The top level holds the FSM, the drop flag and the done pulse.

Test Plan:
- Basic frame: x=3'b101, y=8'hA5, pulse snap_req, sout_ready tied 1. Expected:
  - bits 1,0,1,1,0,1,0,0,1,0,1 on 11 consecutive cycles starting 1 cycle after the request;
  - sout_last only on the 11th bit;
  - snap_done pulse in the following cycle.
- Backpressure: same frame, with sout_ready low on every other cycle. Expected:
  - the bit sequence is unchanged;
  - data and last are stable while ready is low;
  - the frame takes 22 cycles.
- Drop: during a frame, pulse snap_req and change x to 3'b010. Expected:
  - the frame in flight still carries x=101;
  - snap_drop=1 and stays 1;
  - clr_drop clears it on the next cycle.
- Back-to-back: x=0, y=8'hFF, snap_req asserted on the snap_done cycle of a prior frame. Expected:
  - the new frame starts with no gap beyond one cycle;
  - bits 0,0,0 then eight 1s.
- Reset mid-frame: assert rst after bit 4 is accepted. Expected:
  - sout_valid, busy and snap_drop all go 0 asynchronously;
  - no snap_done;
  - a request after release streams the full frame from bit 0.
- Simultaneous set/clear: snap_req while busy in the same cycle as clr_drop. Expected: snap_drop=1 afterwards.
